// File: rtl/segway_pkg.sv
// Shared Segway constants and the signed saturation helper used by the drive-math blocks.
package segway_pkg;

    localparam int SEG_W         = 12;
    localparam int SS_W_DEF      = 8;
    localparam int MIN_DUTY_DEF  = 'h3C0;
    localparam int LOW_BAND_DEF  = 'h3C;
    localparam int GAIN_MULT_DEF = 16;
    localparam int SLEW_STEP_DEF = 'h040;
    localparam int FAST_THR_DEF  = 1792;
    localparam int FAST_CNT_DEF  = 4;

    // Clamp a sign-extended value into the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/segway_slew_lim.sv
// Per-wheel slew limiter: moves the held speed toward the target by at most one step per enabled cycle.
module segway_slew_lim #(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_load_zero,
    input  logic [W-1:0] i_target,
    input  logic [W-1:0] i_step,
    output logic [W-1:0] o_spd,
    output logic [W-1:0] o_spd_next
);

    logic [W-1:0]        r_spd;
    logic signed [W:0]   w_diff;
    logic signed [W:0]   w_step;
    logic [W-1:0]        w_next;

    // One extra bit so a full-scale reversal cannot wrap the difference.
    assign w_diff = $signed({i_target[W-1], i_target}) - $signed({r_spd[W-1], r_spd});
    assign w_step = $signed({1'b0, i_step});

    always_comb begin
        w_next = i_target;
        if (i_load_zero) begin
            w_next = '0;
        end else if (w_diff > w_step) begin
            w_next = r_spd + i_step;
        end else if (w_diff < -w_step) begin
            w_next = r_spd - i_step;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_spd <= '0;
        end else if (i_en) begin
            r_spd <= w_next;
        end
    end

    assign o_spd      = r_spd;
    assign o_spd_next = w_next;

endmodule

// File: rtl/segway_drive_math_pipe.sv
// Three-stage drive math: soft-start/steer prep, torque shaping with saturation, then per-wheel slew
// limiting with a debounced over-speed flag.
module segway_drive_math_pipe
    import segway_pkg::*;
#(
    parameter int W         = SEG_W,
    parameter int SS_W      = SS_W_DEF,
    parameter int MIN_DUTY  = MIN_DUTY_DEF,
    parameter int LOW_BAND  = LOW_BAND_DEF,
    parameter int GAIN_MULT = GAIN_MULT_DEF,
    parameter int SLEW_STEP = SLEW_STEP_DEF,
    parameter int FAST_THR  = FAST_THR_DEF,
    parameter int FAST_CNT  = FAST_CNT_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_vld_in,
    input  logic [W-1:0]    i_pid_cntrl,
    input  logic [SS_W-1:0] i_ss_tmr,
    input  logic [W-1:0]    i_steer_pot,
    input  logic            i_en_steer,
    input  logic            i_pwr_up,
    output logic [W-1:0]    o_lft_spd,
    output logic [W-1:0]    o_rght_spd,
    output logic            o_vld_out,
    output logic            o_too_fast
);

    localparam int PW = W + SS_W + 1;
    localparam int CW = $clog2(FAST_CNT + 1);
    localparam logic [W-1:0]        STEER_LO  = W'((2 ** W) / 8);
    localparam logic [W-1:0]        STEER_HI  = W'((7 * (2 ** W)) / 8);
    localparam logic signed [W:0]   STEER_MID = (W+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [W+1:0] BAND      = (W+2)'(LOW_BAND);
    localparam logic signed [W+1:0] DUTY      = (W+2)'(MIN_DUTY);
    localparam logic signed [W+1:0] GAIN      = (W+2)'(GAIN_MULT);
    localparam logic [W-1:0]        STEP      = W'(SLEW_STEP);
    localparam logic [W-1:0]        THR       = W'(FAST_THR);
    localparam logic [CW-1:0]       CNT_MAX   = CW'(FAST_CNT);

    function automatic logic [W-1:0] shape(input logic signed [W:0] t);
        logic signed [W+1:0] tx;
        logic signed [W+1:0] s;
        tx = {t[W], t};
        if (tx > BAND) begin
            s = tx + DUTY;
        end else if (tx < -BAND) begin
            s = tx - DUTY;
        end else begin
            s = tx * GAIN;
        end
        return W'(sat_signed(32'(s), W));
    endfunction

    // Most negative value maps to 2^(W-1), which still fits unsigned W bits.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? -x : x;
    endfunction

    logic signed [PW-1:0] w_prod;
    logic [W-1:0]         w_pid_ss;
    logic [W-1:0]         w_pot_clamp;
    logic signed [W:0]    w_steer_ctr;
    logic signed [W:0]    w_steer_scl;

    assign w_prod   = PW'($signed(i_pid_cntrl)) * PW'($signed({1'b0, i_ss_tmr}));
    assign w_pid_ss = W'(w_prod >>> SS_W);

    always_comb begin
        w_pot_clamp = i_steer_pot;
        if (i_steer_pot < STEER_LO) begin
            w_pot_clamp = STEER_LO;
        end else if (i_steer_pot > STEER_HI) begin
            w_pot_clamp = STEER_HI;
        end
    end

    assign w_steer_ctr = $signed({1'b0, w_pot_clamp}) - STEER_MID;
    assign w_steer_scl = (w_steer_ctr >>> 4) + (w_steer_ctr >>> 3);

    logic                 r_v1;
    logic signed [W-1:0]  r_pid_ss;
    logic signed [W:0]    r_steer;
    logic                 r_en_steer1;
    logic                 r_pwr_up1;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v1        <= 1'b0;
            r_pid_ss    <= '0;
            r_steer     <= '0;
            r_en_steer1 <= 1'b0;
            r_pwr_up1   <= 1'b0;
        end else begin
            r_v1        <= i_vld_in;
            r_pid_ss    <= w_pid_ss;
            r_steer     <= w_steer_scl;
            r_en_steer1 <= i_en_steer;
            r_pwr_up1   <= i_pwr_up;
        end
    end

    logic signed [W:0] w_pid_x;
    logic signed [W:0] w_t_lft;
    logic signed [W:0] w_t_rght;

    assign w_pid_x  = {r_pid_ss[W-1], r_pid_ss};
    assign w_t_lft  = r_en_steer1 ? (w_pid_x + r_steer) : w_pid_x;
    assign w_t_rght = r_en_steer1 ? (w_pid_x - r_steer) : w_pid_x;

    logic         r_v2;
    logic [W-1:0] r_tgt_lft;
    logic [W-1:0] r_tgt_rght;
    logic         r_pwr_up2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v2       <= 1'b0;
            r_tgt_lft  <= '0;
            r_tgt_rght <= '0;
            r_pwr_up2  <= 1'b0;
        end else begin
            r_v2       <= r_v1;
            r_tgt_lft  <= shape(w_t_lft);
            r_tgt_rght <= shape(w_t_rght);
            r_pwr_up2  <= r_pwr_up1;
        end
    end

    logic [W-1:0] w_lft_next;
    logic [W-1:0] w_rght_next;

    segway_slew_lim #(.W(W)) u_slew_lft (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (r_v2),
        .i_load_zero (!r_pwr_up2),
        .i_target    (r_tgt_lft),
        .i_step      (STEP),
        .o_spd       (o_lft_spd),
        .o_spd_next  (w_lft_next)
    );

    segway_slew_lim #(.W(W)) u_slew_rght (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (r_v2),
        .i_load_zero (!r_pwr_up2),
        .i_target    (r_tgt_rght),
        .i_step      (STEP),
        .o_spd       (o_rght_spd),
        .o_spd_next  (w_rght_next)
    );

    logic          w_over;
    logic [CW-1:0] r_cnt;
    logic          r_vld_out;

    assign w_over = (mag(w_lft_next) > THR) || (mag(w_rght_next) > THR);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_vld_out <= 1'b0;
        end else begin
            r_vld_out <= r_v2;
            if (r_v2) begin
                if (!r_pwr_up2 || !w_over) begin
                    r_cnt <= '0;
                end else if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_vld_out  = r_vld_out;
    assign o_too_fast = (r_cnt == CNT_MAX);

endmodule
